// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: buffers {pc, instr} pairs,
// presents the head show-ahead to decode, and discards everything on a taken-branch flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_valid_i,
    input  logic [31:0]      fetch_instr_i,
    input  logic [31:0]      fetch_pc_i,
    output logic             fetch_ready_o,
    output logic             dec_valid_o,
    output logic [31:0]      dec_instr_o,
    output logic [31:0]      dec_pc_o,
    input  logic             dec_ready_i,
    input  logic             flush_i,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    logic [63:0]      mem [DEPTH];
    logic [63:0]      head_entry;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;

    logic             push;
    logic             pop;

    // Handshake status is a pure function of occupancy, never of dec_ready_i.
    assign fetch_ready_o = (count_reg < FULL_COUNT);
    assign dec_valid_o   = (count_reg != '0);
    assign count_o       = count_reg;

    assign push = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign pop  = dec_valid_o & dec_ready_i & ~flush_i;

    // Empty queue shows an all-zero word so decode sees a bubble with zero immediate.
    assign head_entry  = mem[rd_ptr_reg];
    assign dec_instr_o = dec_valid_o ? head_entry[31:0]  : 32'b0;
    assign dec_pc_o    = dec_valid_o ? head_entry[63:32] : 32'b0;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + ONE_PTR;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + ONE_PTR;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + ONE_COUNT;
                2'b01:   count_next = count_reg - ONE_COUNT;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= {fetch_pc_i, fetch_instr_i};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk_i;
    logic             rst_i;
    logic             fetch_valid_i;
    logic [31:0]      fetch_instr_i;
    logic [31:0]      fetch_pc_i;
    logic             fetch_ready_o;
    logic             dec_valid_o;
    logic [31:0]      dec_instr_o;
    logic [31:0]      dec_pc_o;
    logic             dec_ready_i;
    logic             flush_i;
    logic [PTR_W:0]   count_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: entries held as {pc, instr}, head at index 0.
    logic [63:0] model_q[$];

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .fetch_valid_i(fetch_valid_i),
        .fetch_instr_i(fetch_instr_i),
        .fetch_pc_i(fetch_pc_i),
        .fetch_ready_o(fetch_ready_o),
        .dec_valid_o(dec_valid_o),
        .dec_instr_o(dec_instr_o),
        .dec_pc_o(dec_pc_o),
        .dec_ready_i(dec_ready_i),
        .flush_i(flush_i),
        .count_o(count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock and update the model from the inputs currently applied.
    task automatic cycle();
        bit do_push;
        bit do_pop;
        do_push = fetch_valid_i && (model_q.size() < DEPTH) && !flush_i;
        do_pop  = dec_ready_i && (model_q.size() > 0) && !flush_i;
        @(posedge clk_i);
        #1;
        if (flush_i) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({fetch_pc_i, fetch_instr_i});
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        fetch_valid_i = 1'b0; fetch_instr_i = '0; fetch_pc_i = '0;
        dec_ready_i = 1'b0; flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #3 rst_i = 1'b1;
        model_q.delete();
        @(posedge clk_i); #1;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
        n_cmp++; if (dec_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", dec_valid_o); end
        n_cmp++; if (dec_instr_o !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", dec_instr_o); end
        n_cmp++; if (dec_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", dec_pc_o); end
        n_cmp++; if (fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", fetch_ready_o); end
        $display("reset: count=%0d valid=%0b ready=%0b", count_o, dec_valid_o, fetch_ready_o);
    endtask

    task automatic test_pass_through();
        fetch_valid_i = 1'b1; fetch_instr_i = 32'h00500093; fetch_pc_i = 32'h0; dec_ready_i = 1'b1;
        n_cmp++; if (dec_valid_o !== 1'b0) begin n_err++; $display("FAIL pass_no_bypass got %0b want 0", dec_valid_o); end
        cycle();
        fetch_valid_i = 1'b0;
        n_cmp++; if (dec_valid_o !== 1'b1) begin n_err++; $display("FAIL pass_valid got %0b want 1", dec_valid_o); end
        n_cmp++; if (dec_instr_o !== 32'h00500093) begin n_err++; $display("FAIL pass_instr got %h want 00500093", dec_instr_o); end
        n_cmp++; if (dec_pc_o !== 32'h0) begin n_err++; $display("FAIL pass_pc got %h want 0", dec_pc_o); end
        n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL pass_count1 got %0d want 1", count_o); end
        cycle();
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL pass_count0 got %0d want 0", count_o); end
        n_cmp++; if (dec_valid_o !== 1'b0) begin n_err++; $display("FAIL pass_empty got %0b want 0", dec_valid_o); end
        $display("pass_through: instr 00500093 pc 0 done, count=%0d", count_o);
    endtask

    task automatic test_fill_stall();
        logic [31:0] instrs [5];
        for (int i = 0; i < 5; i++) instrs[i] = $urandom;
        dec_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch_valid_i = 1'b1; fetch_pc_i = 32'(4 * i); fetch_instr_i = instrs[i];
            cycle();
            n_cmp++; if (dec_pc_o !== 32'h0) begin n_err++; $display("FAIL fill_head_pc got %h want 0", dec_pc_o); end
        end
        // Fifth instruction held upstream while full and stalled.
        fetch_valid_i = 1'b1; fetch_pc_i = 32'd16; fetch_instr_i = instrs[4];
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count_o); end
            n_cmp++; if (fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_ready got %0b want 0", fetch_ready_o); end
            n_cmp++; if (dec_instr_o !== instrs[0]) begin n_err++; $display("FAIL fill_head_instr got %h want %h", dec_instr_o, instrs[0]); end
            cycle();
        end
        dec_ready_i = 1'b1;
        cycle();  // pops pc 0, push blocked because full at the edge
        n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL fill_after_pop count got %0d want 3", count_o); end
        n_cmp++; if (dec_pc_o !== 32'd4) begin n_err++; $display("FAIL fill_order pc got %0d want 4", dec_pc_o); end
        cycle();  // pops pc 4, fifth accepted
        fetch_valid_i = 1'b0;
        n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL fill_fifth count got %0d want 3", count_o); end
        for (int i = 2; i < 5; i++) begin
            n_cmp++; if (dec_pc_o !== 32'(4 * i) || dec_instr_o !== instrs[i]) begin
                n_err++; $display("FAIL fill_drain pc got %0d/%h want %0d/%h", dec_pc_o, dec_instr_o, 4 * i, instrs[i]);
            end
            cycle();
        end
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL fill_end count got %0d want 0", count_o); end
        $display("fill_stall: 5 instrs in order, count=%0d", count_o);
    endtask

    task automatic test_wrap();
        dec_ready_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            fetch_valid_i = (i < 10);
            fetch_pc_i = 32'h100 + 32'(4 * i);
            fetch_instr_i = $urandom;
            cycle();
            if (i < 10) begin
                n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL wrap_count got %0d want 1", count_o); end
                n_cmp++; if (dec_pc_o !== 32'h100 + 32'(4 * i)) begin
                    n_err++; $display("FAIL wrap_order got %h want %h", dec_pc_o, 32'h100 + 32'(4 * i));
                end
            end
        end
        fetch_valid_i = 1'b0;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL wrap_end got %0d want 0", count_o); end
        $display("wrap: 10 instrs streamed, count=%0d", count_o);
    endtask

    task automatic test_flush();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_valid_i = 1'b1; fetch_pc_i = 32'h200 + 32'(4 * i); fetch_instr_i = $urandom;
            cycle();
        end
        n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL flush_pre got %0d want 3", count_o); end
        flush_i = 1'b1; fetch_valid_i = 1'b1; dec_ready_i = 1'b1; fetch_instr_i = 32'hDEADBEEF;
        cycle();
        flush_i = 1'b0; fetch_valid_i = 1'b0; dec_ready_i = 1'b0;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", count_o); end
        n_cmp++; if (dec_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", dec_valid_o); end
        n_cmp++; if (dec_instr_o !== 32'h0) begin n_err++; $display("FAIL flush_instr got %h want 0", dec_instr_o); end
        n_cmp++; if (fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0b want 1", fetch_ready_o); end
        cycle();
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL flush_no_store got %0d want 0", count_o); end
        $display("flush: count=%0d valid=%0b", count_o, dec_valid_o);
    endtask

    task automatic test_async_reset();
        dec_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fetch_valid_i = 1'b1; fetch_pc_i = 32'h300 + 32'(4 * i); fetch_instr_i = $urandom;
            cycle();
        end
        fetch_valid_i = 1'b0;
        n_cmp++; if (count_o !== 3'd2) begin n_err++; $display("FAIL areset_pre got %0d want 2", count_o); end
        #2 rst_i = 1'b0;   // between edges
        model_q.delete();
        #1;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL areset_count got %0d want 0", count_o); end
        n_cmp++; if (dec_valid_o !== 1'b0) begin n_err++; $display("FAIL areset_valid got %0b want 0", dec_valid_o); end
        n_cmp++; if (dec_pc_o !== 32'h0) begin n_err++; $display("FAIL areset_pc got %h want 0", dec_pc_o); end
        n_cmp++; if (fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL areset_ready got %0b want 1", fetch_ready_o); end
        #2 rst_i = 1'b1;
        fetch_valid_i = 1'b1; fetch_pc_i = 32'h400; fetch_instr_i = 32'h00100113;
        cycle();
        fetch_valid_i = 1'b0;
        n_cmp++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h400 || dec_instr_o !== 32'h00100113) begin
            n_err++; $display("FAIL areset_resume got %0b/%h/%h want 1/400/00100113", dec_valid_o, dec_pc_o, dec_instr_o);
        end
        dec_ready_i = 1'b1;
        cycle();
        $display("async_reset: resumed, count=%0d", count_o);
    endtask

    task automatic test_random();
        logic [31:0] exp_instr, exp_pc;
        logic        exp_valid;
        logic [63:0] head;
        for (int i = 0; i < 300; i++) begin
            fetch_valid_i = ($urandom_range(3) != 0);
            dec_ready_i   = ($urandom_range(2) != 0);
            flush_i       = ($urandom_range(15) == 0);
            fetch_pc_i    = $urandom;
            fetch_instr_i = $urandom;
            cycle();
            exp_valid = (model_q.size() != 0);
            head = exp_valid ? model_q[0] : 64'h0;
            exp_pc = head[63:32];
            exp_instr = head[31:0];
            n_cmp++;
            if (count_o !== 3'(model_q.size()) || dec_valid_o !== exp_valid ||
                dec_instr_o !== exp_instr || dec_pc_o !== exp_pc ||
                fetch_ready_o !== (model_q.size() < DEPTH)) begin
                n_err++;
                $display("FAIL random[%0d] got cnt=%0d v=%0b pc=%h in=%h rdy=%0b want cnt=%0d v=%0b pc=%h in=%h",
                         i, count_o, dec_valid_o, dec_pc_o, dec_instr_o, fetch_ready_o,
                         model_q.size(), exp_valid, exp_pc, exp_instr);
            end
        end
        fetch_valid_i = 1'b0; flush_i = 1'b0;
        $display("random: 300 cycles checked");
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fill_stall();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small instruction prefetch queue between instruction memory/PC fetch logic and the decode stage (register file read, immediate generation, control).
- Buffers fetched instruction/PC pairs so fetch can keep running while decode stalls on a load-use hazard.
- Discards all buffered instructions on a taken-branch flush.
- Presents the head entry to decode with a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- fetch_valid_i  input  1  fetch side presents an instruction this cycle.
- fetch_instr_i  input  32  fetched instruction word.
- fetch_pc_i  input  32  PC of the fetched instruction.
- fetch_ready_o  output  1  queue can accept an entry this cycle.
- dec_valid_o  output  1  head entry valid for decode.
- dec_instr_o  output  32  head instruction to decode/immediate generation.
- dec_pc_o  output  32  head PC.
- dec_ready_i  input  1  decode consumes the head this cycle; driven low on hazard stall.
- flush_i  input  1  taken branch; discard all entries.
- count_o  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock/reset: one clock, clk_i. rst_i is asynchronous, active-low.
- Reset (rst_i low, async):
  - read pointer, write pointer and count cleared to 0.
  - dec_valid_o=0, dec_instr_o=0, dec_pc_o=0, count_o=0, fetch_ready_o=1.
  - Storage contents don't-care.
- Storage: DEPTH-entry array of {pc, instr}. Pointers wrap modulo DEPTH (DEPTH-1 -> 0).
- Show-ahead output:
  - dec_instr_o/dec_pc_o reflect the head entry combinationally from registered storage.
  - When count=0: dec_valid_o=0 and dec_instr_o=32'b0, dec_pc_o=32'b0. Decode treats an all-zero word as a bubble with zero immediate.
- fetch_ready_o = (count < DEPTH). Depends on state only, never on dec_ready_i.
- Push: fetch_valid_i & fetch_ready_o & ~flush_i. Writes the entry at the write pointer; write pointer +1.
- Pop: dec_valid_o & dec_ready_i & ~flush_i. Read pointer +1.
- Push and pop in the same cycle: both occur, count unchanged.
- Count: +1 on push only, -1 on pop only, else hold.
- Latency: an entry pushed in cycle N is visible at the decode outputs in cycle N+1 (no same-cycle bypass when empty).
- Full (count=DEPTH):
  - fetch_ready_o=0, so no push even if a pop occurs that cycle.
  - The freed slot becomes available the next cycle.
- Empty: a pop cannot occur because dec_valid_o=0.
- Flush (flush_i=1 at clock edge):
  - pointers and count set to 0.
  - any concurrent push and pop are ignored.
  - next cycle dec_valid_o=0, count_o=0, fetch_ready_o=1.
  - flush takes priority over all other events.
- Stall: dec_ready_i=0 holds the head stable (dec_instr_o/dec_pc_o unchanged) for any number of cycles. Fetch continues filling until full.
- Reset asserted mid-operation: immediate async clear per the reset values above. On deassertion the first push is accepted on the next clock edge.
- No error outputs. Push while full or pop while empty is impossible by construction and leaves state unchanged.

Test Plan:
- Reset/idle: hold rst_i low, then release -> count_o=0, dec_valid_o=0, dec_instr_o=0, fetch_ready_o=1.
- Single pass-through: push instr 32'h00500093 at pc 32'h0 in cycle N, dec_ready_i=1 -> dec_valid_o=1 with that instr/pc in cycle N+1, popped, count_o back to 0 in N+2.
- Fill while stalled: dec_ready_i=0, push 5 consecutive instrs (pc 0,4,8,12,16):
  - first 4 accepted; count_o=4; fetch_ready_o=0; 5th held upstream.
  - head stays pc 0 throughout.
  - then dec_ready_i=1 -> outputs pc 0,4,8,12 in order, and the 5th is accepted the cycle after the first pop.
- Wrap-around: stream 10 instructions with continuous push/pop at 1 per cycle -> count_o steady at 1, order preserved across pointer wrap, no drops.
- Flush priority: count_o=3, assert flush_i together with fetch_valid_i=1 and dec_ready_i=1 -> next cycle count_o=0, dec_valid_o=0, dec_instr_o=0, pushed instr not stored.
- Async reset mid-stream: with count_o=2, pull rst_i low between clock edges -> outputs clear immediately without a clock edge; normal pushes resume after release.
